// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC capture buffer.
package adc_capture_pkg;

  typedef enum logic [1:0] {
    SETTLE,
    CAPTURE,
    DONE
  } state_t;

  localparam int DROP_CNT_W = 16;

  function automatic int lane_idx_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/adc_capture_buffer_sdp_ram.sv
// Simple dual-port RAM, one clock, registered read port; maps onto block RAM.
module sdp_ram_1clk #(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register only updates on a read so the selected sample holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/adc_capture_buffer.sv
// ADC capture buffer: settle, then store LANES-wide words and read back one sample at a time.
// Optional build macro DROP_CNT_EN adds a saturating drop_cnt output.
module adc_capture_buffer
  import adc_capture_pkg::*;
#(
  parameter int SAMPLE_W   = 16,
  parameter int LANES      = 4,
  parameter int DEPTH_LOG2 = 10,
  parameter int SETTLE_W   = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wen,
  input  logic [LANES*SAMPLE_W-1:0] din,
  input  logic                      oneshot,
  input  logic                      clr,
  input  logic                      rden,
  output logic [SAMPLE_W-1:0]       dout,
  output logic                      dout_vld,
  output logic                      empty,
  output logic                      full,
  output logic [DEPTH_LOG2:0]       level,
  output logic                      overflow,
`ifdef DROP_CNT_EN
  output logic [DROP_CNT_W-1:0]     drop_cnt,
`endif
  output logic                      done
);

  localparam int LANE_IDX_W = lane_idx_w(LANES);
  localparam int PTR_W      = DEPTH_LOG2 + 1;
  localparam logic [PTR_W-1:0]      FULL_LVL  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(LANES - 1);

  state_t                   state, state_nxt;
  logic [SETTLE_W-1:0]      settle_cnt;
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [LANE_IDX_W-1:0]    lane_idx, lane_sel_p1;
  logic [LANES*SAMPLE_W-1:0] word_p1;
  logic                     wr_acc, rd_acc, drop, last_lane;

  assign full      = (level == FULL_LVL);
  assign empty     = (level == '0);
  assign done      = (state == DONE);
  assign last_lane = (lane_idx == LAST_LANE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SETTLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_acc    = 1'b0;
    drop      = 1'b0;
    rd_acc    = rden && !empty && !clr;
    case (state)
      SETTLE:  if (&settle_cnt) state_nxt = CAPTURE;
      CAPTURE: begin
        wr_acc = wen && !full && !clr;
        drop   = wen && full && !clr;
        if (!clr && oneshot && full) state_nxt = DONE;
      end
      DONE:    if (clr) state_nxt = CAPTURE;
      default: state_nxt = SETTLE;
    endcase
  end

  // Settle count survives clr; only reset restarts the settle interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) settle_cnt <= '0;
    else if (state == SETTLE && wen && !(&settle_cnt)) settle_cnt <= settle_cnt + SETTLE_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      lane_idx    <= '0;
      lane_sel_p1 <= '0;
      level       <= '0;
      overflow    <= 1'b0;
      dout_vld    <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      lane_idx <= '0;
      level    <= '0;
      overflow <= 1'b0;
      dout_vld <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) begin
        lane_idx    <= lane_idx + LANE_IDX_W'(1);
        lane_sel_p1 <= lane_idx;
        if (last_lane) rd_ptr <= rd_ptr + PTR_W'(1);
      end
      dout_vld <= rd_acc;
      if (drop) overflow <= 1'b1;
      case ({wr_acc, rd_acc && last_lane})
        2'b10:   level <= level + PTR_W'(1);
        2'b01:   level <= level - PTR_W'(1);
        default: level <= level;
      endcase
    end
  end

`ifdef DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      drop_cnt <= '0;
    else if (clr)                    drop_cnt <= '0;
    else if (drop && !(&drop_cnt))   drop_cnt <= drop_cnt + DROP_CNT_W'(1);
  end
`endif

  sdp_ram_1clk #(
    .WIDTH (LANES * SAMPLE_W),
    .ADDR_W(DEPTH_LOG2)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (wr_acc),
    .waddr(wr_ptr[DEPTH_LOG2-1:0]),
    .wdata(din),
    .re   (rd_acc),
    .raddr(rd_ptr[DEPTH_LOG2-1:0]),
    .rdata(word_p1)
  );

  // Stage p1: registered RAM word, lane chosen by the lane index captured with the read.
  always_comb begin
    dout = '0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_sel_p1 == k[LANE_IDX_W-1:0]) dout = word_p1[k*SAMPLE_W +: SAMPLE_W];
    end
  end

endmodule
